sm_arbiter: RTL and testbench

Round-robin arbiter that shares one 16x16 sequential multiplier (SM) between NUM_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and sequences the SM's start/ready protocol. It returns each 32-bit product to the requester that issued it. It sits between client blocks and the single SM instance, and owns all of that SM's control inputs.

---
 rtl/sm_arbiter_if.sv | 37 +++
 rtl/sm_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_sm_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sm_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sm_arbiter_if
// Purpose  : Client-side bus of the sequential-multiplier arbiter. It carries
//            the per-requester operand handshake and the response channel
//            back to the owning requester.
// Ports    : req_valid/req_ready     per-requester request handshake
//            req_a/req_b             packed 16-bit operands, requester i at
//                                    [16i+15:16i]
//            rsp_valid/rsp_ready     one-hot response handshake
//            rsp_product/rsp_error   response payload
// Modports : master = client side, slave = arbiter side
// Revision : 1.0 - initial release
// ============================================================================
interface sm_arbiter_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [16*NUM_REQ-1:0] req_a;
   logic [16*NUM_REQ-1:0] req_b;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [31:0]           rsp_product;
   logic                  rsp_error;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_product, rsp_error
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_product, rsp_error
   );
endinterface
`default_nettype wire

// File: rtl/sm_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm_arbiter
// Purpose  : Round-robin arbiter sharing one 16x16 sequential multiplier (SM)
//            between NUM_REQ requesters. One transaction is in flight at a
//            time; the product is returned to the requester that issued it.
// Ports    : clk, reset           clock, synchronous active-high reset
//            bus (slave)          client request/response bus
//            sm_start             one-cycle start pulse to the SM
//            sm_multiplicand/
//            sm_multiplier        operands held stable for the transaction
//            sm_product/sm_ready  SM result and idle/done indication
// Options  : SM_ARB_TIMEOUT_EN    when defined, a watchdog ends a transaction
//                                 that has not completed within TIMEOUT
//                                 cycles and responds with rsp_error=1.
// Revision : 1.0 - initial release
// ============================================================================
module sm_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        reset,
   sm_arbiter_if.slave bus,
   output logic        sm_start,
   output logic [15:0] sm_multiplicand,
   output logic [15:0] sm_multiplier,
   input  logic [31:0] sm_product,
   input  logic        sm_ready
);
   localparam int PTR_W = $clog2(NUM_REQ);

   // Elaboration-time sanity checks on the configuration.
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("sm_arbiter: NUM_REQ must lie in 2..8");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("sm_arbiter: TIMEOUT must be at least 1");
   end

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_WAIT_BUSY = 3'd2,
      ST_WAIT_DONE = 3'd3,
      ST_RESP      = 3'd4
   } state_t;

   state_t             r_state;
   logic [PTR_W-1:0]   r_ptr;
   logic [PTR_W-1:0]   r_owner;
   logic [NUM_REQ-1:0] r_rsp_valid;
   logic [31:0]        r_result;
   logic               r_start;
   logic [15:0]        r_op_a;
   logic [15:0]        r_op_b;

   logic [PTR_W-1:0]   w_grant;
   logic               w_grant_found;
   logic               w_accept;
   logic [NUM_REQ-1:0] w_req_ready;
   logic [NUM_REQ-1:0] w_owner_onehot;
   logic               w_timeout;

   // Round-robin search starting at ptr+1. Scanning from the farthest
   // offset down lets the nearest valid requester win the last assignment.
   always_comb begin
      w_grant       = r_ptr;
      w_grant_found = 1'b0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_grant       = PTR_W'((int'(r_ptr) + k) % NUM_REQ);
            w_grant_found = 1'b1;
         end
      end
   end

   // A grant needs an idle SM; the grant itself is the handshake.
   assign w_accept = (r_state == ST_IDLE) && !reset && sm_ready && w_grant_found;

   always_comb begin
      w_req_ready = '0;
      if (w_accept) begin
         w_req_ready[w_grant] = 1'b1;
      end
   end

   always_comb begin
      w_owner_onehot          = '0;
      w_owner_onehot[r_owner] = 1'b1;
   end

`ifdef SM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_rsp_error;

   // Counts cycles spent in the two wait states; fires on the TIMEOUT-th.
   always_ff @(posedge clk) begin
      if (reset || r_state == ST_START) begin
         r_wait_cnt <= '0;
      end else if (r_state == ST_WAIT_BUSY || r_state == ST_WAIT_DONE) begin
         r_wait_cnt <= r_wait_cnt + 1'b1;
      end
   end

   assign w_timeout     = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
   assign bus.rsp_error = r_rsp_error;
`else
   assign w_timeout     = 1'b0;
   assign bus.rsp_error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_ptr       <= PTR_W'(NUM_REQ - 1);
         r_owner     <= '0;
         r_rsp_valid <= '0;
         r_result    <= '0;
         r_start     <= 1'b0;
         r_op_a      <= '0;
         r_op_b      <= '0;
`ifdef SM_ARB_TIMEOUT_EN
         r_rsp_error <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op_a  <= bus.req_a[16*int'(w_grant) +: 16];
                  r_op_b  <= bus.req_b[16*int'(w_grant) +: 16];
                  r_owner <= w_grant;
                  r_start <= 1'b1;
                  r_state <= ST_START;
               end
            end
            ST_START: begin
               r_start <= 1'b0;
               r_state <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (w_timeout) begin
                  r_result    <= '0;
                  r_rsp_valid <= w_owner_onehot;
`ifdef SM_ARB_TIMEOUT_EN
                  r_rsp_error <= 1'b1;
`endif
                  r_state     <= ST_RESP;
               end else if (!sm_ready) begin
                  r_state <= ST_WAIT_DONE;
               end
            end
            ST_WAIT_DONE: begin
               // A completion seen on the same cycle as the timeout wins.
               if (sm_ready) begin
                  r_result    <= sm_product;
                  r_rsp_valid <= w_owner_onehot;
`ifdef SM_ARB_TIMEOUT_EN
                  r_rsp_error <= 1'b0;
`endif
                  r_state     <= ST_RESP;
               end else if (w_timeout) begin
                  r_result    <= '0;
                  r_rsp_valid <= w_owner_onehot;
`ifdef SM_ARB_TIMEOUT_EN
                  r_rsp_error <= 1'b1;
`endif
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               // Only the owner's rsp_ready can complete the response.
               if (bus.rsp_ready[r_owner]) begin
                  r_rsp_valid <= '0;
                  r_ptr       <= r_owner;
`ifdef SM_ARB_TIMEOUT_EN
                  r_rsp_error <= 1'b0;
`endif
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = w_req_ready;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_product = r_result;
   assign sm_start        = r_start;
   assign sm_multiplicand = r_op_a;
   assign sm_multiplier   = r_op_b;
endmodule
`default_nettype wire

// File: tb/tb_sm_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sm_arbiter
// Purpose  : Directed self-checking bench for sm_arbiter with a behavioural
//            sequential multiplier and an expected-response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sm_arbiter;
   localparam int NUM_REQ = 4;
   localparam int TIMEOUT = 64;

   typedef struct {
      int          owner;
      logic [31:0] product;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        sm_start;
   logic [15:0] sm_multiplicand;
   logic [15:0] sm_multiplier;
   logic [31:0] sm_product;
   logic        sm_ready;

   always #5 clk = ~clk;

   sm_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   sm_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .sm_start        (sm_start),
      .sm_multiplicand (sm_multiplicand),
      .sm_multiplier   (sm_multiplier),
      .sm_product      (sm_product),
      .sm_ready        (sm_ready)
   );

   // Behavioural SM: takes a start while idle, drops ready, and after
   // sm_lat cycles raises ready with the product. sm_hang freezes it busy.
   int          sm_lat  = 3;
   bit          sm_hang = 1'b0;
   int          sm_cnt;
   logic [31:0] sm_pending;
   int          start_pulses = 0;

   always @(posedge clk) begin
      if (reset) begin
         sm_ready   <= 1'b1;
         sm_product <= '0;
         sm_cnt     <= 0;
         sm_pending <= '0;
      end else if (sm_ready) begin
         if (sm_start) begin
            sm_ready   <= 1'b0;
            sm_cnt     <= sm_lat;
            sm_pending <= {16'h0, sm_multiplicand} * {16'h0, sm_multiplier};
         end
      end else if (!sm_hang) begin
         if (sm_cnt <= 1) begin
            sm_ready   <= 1'b1;
            sm_product <= sm_pending;
         end else begin
            sm_cnt <= sm_cnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (!reset && sm_start) start_pulses <= start_pulses + 1;
   end

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Present a request and record the response it must eventually produce.
   task automatic drive(input int idx, input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      bus.req_a[16*idx +: 16] = a;
      bus.req_b[16*idx +: 16] = b;
      bus.req_valid[idx]      = 1'b1;
      e.owner   = idx;
      e.product = {16'h0, a} * {16'h0, b};
      e.err     = 1'b0;
      sb.push_back(e);
   endtask

   task automatic wait_grant(input int idx, input string tag);
      int n = 0;
      #1;
      while (bus.req_ready == '0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(bus.req_ready), 64'(1 << idx));
   endtask

   // Grant seen at this negedge; the next negedge follows the handshake edge.
   task automatic after_grant(input int idx, input string tag);
      @(negedge clk);
      bus.req_valid[idx] = 1'b0;
      check(tag, 64'(sm_start), 64'd1);
   endtask

   task automatic wait_rsp(input string tag, input bit check_lat);
      int   n   = 0;
      int   rdy = 0;
      exp_t e;
      while (bus.rsp_valid == '0 && n < 200) begin
         if (sm_ready) rdy++;
         else          rdy = 0;
         @(negedge clk);
         n++;
      end
      check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, "_rsp_valid"},   64'(bus.rsp_valid),   64'(1 << e.owner));
         check({tag, "_rsp_product"}, 64'(bus.rsp_product), 64'(e.product));
         check({tag, "_rsp_error"},   64'(bus.rsp_error),   64'(e.err));
      end
      if (check_lat) check({tag, "_rsp_latency"}, 64'(rdy), 64'd1);
   endtask

   task automatic ack(input int idx, input string tag);
      bus.rsp_ready[idx] = 1'b1;
      @(negedge clk);
      bus.rsp_ready = '0;
      check(tag, 64'(bus.rsp_valid), 64'd0);
   endtask

   task automatic run_txn(input int idx, input logic [15:0] a, input logic [15:0] b, input string tag);
      drive(idx, a, b);
      wait_grant(idx, {tag, "_grant"});
      after_grant(idx, {tag, "_start"});
      wait_rsp(tag, 1'b1);
      ack(idx, {tag, "_ack"});
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] stall_prod;
      int          base;
      int          seen;

      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_req_ready",   64'(bus.req_ready),   64'd0);
      check("rst_rsp_valid",   64'(bus.rsp_valid),   64'd0);
      check("rst_rsp_product", 64'(bus.rsp_product), 64'd0);
      check("rst_rsp_error",   64'(bus.rsp_error),   64'd0);
      check("rst_sm_start",    64'(sm_start),        64'd0);
      check("rst_operands",    64'({sm_multiplicand, sm_multiplier}), 64'd0);

      // Req 0: 3*5, grant in the same cycle, start one cycle later
      drive(0, 16'd3, 16'd5);
      #1;
      check("t1_req_ready_comb", 64'(bus.req_ready), 64'b0001);
      after_grant(0, "t1_sm_start");
      check("t1_operands", 64'({sm_multiplicand, sm_multiplier}), 64'h0003_0005);
      @(negedge clk);
      check("t1_start_single", 64'(sm_start), 64'd0);
      wait_rsp("t1", 1'b1);
      ack(0, "t1_ack");

      // Req 2: extreme and zero operands
      run_txn(2, 16'hFFFF, 16'hFFFF, "t2_max");
      run_txn(2, 16'h1234, 16'h0000, "t2_zero");

      // All four requesting from reset: service order 0,1,2,3
      pulse_reset();
      drive(0, 16'd10,    16'd11);
      drive(1, 16'h0100,  16'h0200);
      drive(2, 16'hABCD,  16'd2);
      drive(3, 16'h8000,  16'h8000);
      base = start_pulses;
      for (int k = 0; k < NUM_REQ; k++) begin
         wait_grant(k, "t3_grant_order");
         after_grant(k, "t3_start");
         wait_rsp("t3", 1'b1);
         ack(k, "t3_ack");
      end
      check("t3_start_pulses", 64'(start_pulses - base), 64'd4);

      // Req 1 response stalled for 10 cycles while req 0 waits
      stall_prod = 32'h0102 * 32'h0304;
      drive(1, 16'h0102, 16'h0304);
      wait_grant(1, "t4_grant");
      after_grant(1, "t4_start");
      wait_rsp("t4", 1'b1);
      drive(0, 16'd9, 16'd9);
      bus.rsp_ready[0] = 1'b1;    // non-owner accept must be ignored
      base = start_pulses;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("t4_hold_valid",   64'(bus.rsp_valid),   64'b0010);
         check("t4_hold_product", 64'(bus.rsp_product), 64'(stall_prod));
         check("t4_hold_no_grant", 64'(bus.req_ready),  64'd0);
      end
      check("t4_no_start", 64'(start_pulses - base), 64'd0);
      bus.rsp_ready = '0;
      ack(1, "t4_ack");
      check("t4_next_grant", 64'(bus.req_ready), 64'b0001);
      after_grant(0, "t4_start0");
      wait_rsp("t4_req0", 1'b1);
      ack(0, "t4_ack0");

      // Reset during WAIT_DONE of a req 3 transaction
      sm_lat = 20;
      drive(3, 16'h0055, 16'h0066);
      wait_grant(3, "t5_grant");
      after_grant(3, "t5_start");
      seen = 0;
      while (sm_ready && seen < 20) begin
         @(negedge clk);
         seen++;
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("t5_rst_rsp_valid", 64'(bus.rsp_valid),   64'd0);
      check("t5_rst_product",   64'(bus.rsp_product), 64'd0);
      check("t5_rst_sm_start",  64'(sm_start),        64'd0);
      check("t5_rst_operands",  64'({sm_multiplicand, sm_multiplier}), 64'd0);
      check("t5_rst_req_ready", 64'(bus.req_ready),   64'd0);
      reset = 1'b0;
      sb.delete();
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (bus.rsp_valid != '0) seen++;
      end
      check("t5_no_response", 64'(seen), 64'd0);
      sm_lat = 3;
      run_txn(0, 16'd7, 16'd6, "t5_after");

      // SM that never completes
      sm_hang = 1'b1;
      drive(1, 16'd2, 16'd3);
      wait_grant(1, "t6_grant");
      after_grant(1, "t6_start");
`ifdef SM_ARB_TIMEOUT_EN
      begin
         exp_t e;
         void'(sb.pop_back());
         e.owner   = 1;
         e.product = '0;
         e.err     = 1'b1;
         sb.push_back(e);
      end
      wait_rsp("t6_timeout", 1'b0);
      ack(1, "t6_ack");
`else
      seen = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (bus.rsp_valid != '0) seen++;
      end
      check("t6_no_response", 64'(seen), 64'd0);
      check("t6_operands_held", 64'({sm_multiplicand, sm_multiplier}), 64'h0002_0003);
      sb.delete();
`endif
      sm_hang = 1'b0;
      pulse_reset();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
